// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] DAB_THRESH = 4'd5;
    localparam logic [3:0] DAB_ADD    = 4'd3;

    // Digits needed for a w-bit unsigned value; 8^k < 10^k keeps this sufficient.
    function automatic int bcd_digits(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/bin2bcd_dab_digit.sv
// One BCD digit correction cell: values of 5 or more get +3 so the next left shift carries correctly.
module bin2bcd_dab_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= DAB_THRESH) ? (d_i + DAB_ADD) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement and report the sign on out_neg.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*bcd_digits(W)-1:0] out_bcd,
    output logic              out_neg,
    output logic              busy
);

    localparam int ND    = bcd_digits(W);
    localparam int BW    = 4 * ND;
    localparam int CNT_W = $clog2(W);

    state_t           state_q;
    logic [W-1:0]     bin_sr_q;
    logic [BW-1:0]    bcd_acc_q;
    logic [BW-1:0]    bcd_acc_d;
    logic [BW-1:0]    bcd_corr;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [BW-1:0]    out_bcd_q;
    logic             out_neg_q;
    logic             busy_q;

    logic [W-1:0]     load_mag;
    logic             load_neg;
    logic             unused_top_bit;

`ifdef BIN2BCD_SIGNED_EN
    logic signed [W-1:0] in_s;
    logic signed [W-1:0] neg_s;

    // Negation stays in W bits so the most negative value maps to 2^(W-1) as unsigned.
    assign in_s     = in_bin;
    assign neg_s    = -in_s;
    assign load_neg = in_bin[W-1];
    assign load_mag = in_bin[W-1] ? $unsigned(neg_s) : in_bin;
`else
    assign load_neg = 1'b0;
    assign load_mag = in_bin;
`endif

    for (genvar g = 0; g < ND; g++) begin : g_dab
        bin2bcd_dab_digit u_digit (
            .d_i (bcd_acc_q[4*g +: 4]),
            .d_o (bcd_corr[4*g +: 4])
        );
    end

    // The top accumulator bit is always zero before the shift, so dropping it loses nothing.
    assign bcd_acc_d      = {bcd_corr[BW-2:0], bin_sr_q[W-1]};
    assign unused_top_bit = bcd_corr[BW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_sr_q    <= '0;
            bcd_acc_q   <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr_q   <= load_mag;
                        bcd_acc_q  <= '0;
                        cnt_q      <= CNT_W'(W - 1);
                        out_bcd_q  <= '0;
                        out_neg_q  <= load_neg;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    bcd_acc_q <= bcd_acc_d;
                    bin_sr_q  <= {bin_sr_q[W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        out_bcd_q   <= bcd_acc_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Result and sign stay on the outputs after the handshake until the next load.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_neg   = out_neg_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: W=16 main instance plus a W=4 minimum-width instance.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [23:0] bcd;
        logic        neg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_bcd;
    logic        out_neg;
    logic        busy;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  in_bin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [7:0]  out_bcd4;
    logic        out_neg4;
    logic        busy4;

    int tot;
    int bad;
    exp_t exp_q[$];

    bin2bcd_seq #(.W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .busy      (busy)
    );

    bin2bcd_seq #(.W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_bin    (in_bin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_bcd   (out_bcd4),
        .out_neg   (out_neg4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_conv(input logic [15:0] v);
        exp_t r;
        int   m;
        r = '0;
        m = int'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[15]) begin
            r.neg = 1'b1;
            m = 65536 - m;
        end
`endif
        for (int i = 0; i < 6; i++) begin
            r.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input logic [15:0] v, input logic [23:0] eb, input logic en, input bit chk);
        int   n;
        exp_t e;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tot++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait v=%0d in_ready=%b required 1", v, in_ready);
        end
        exp_q.push_back('{bcd: eb, neg: en});
        in_bin    = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        if (chk) begin
            tot++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                bad++;
                $display("FAIL accept_flags v=%0d busy/in_ready/out_valid=%b required 100", v, {busy, in_ready, out_valid});
            end
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tot++;
        if (chk ? (n != 16) : (out_valid !== 1'b1)) begin
            bad++;
            $display("FAIL latency v=%0d cycles=%0d required 16", v, n);
        end
        if (chk) begin
            tot++;
            if ({busy, in_ready} !== 2'b00) begin
                bad++;
                $display("FAIL done_flags v=%0d busy/in_ready=%b required 00", v, {busy, in_ready});
            end
        end
        e = exp_q.pop_front();
        tot++;
        if (out_bcd !== e.bcd || out_neg !== e.neg) begin
            bad++;
            $display("FAIL result v=%0d got bcd=%06h neg=%b required bcd=%06h neg=%b", v, out_bcd, out_neg, e.bcd, e.neg);
        end
        tick();
        if (chk) begin
            tot++;
            if ({out_valid, in_ready} !== 2'b01 || out_bcd !== e.bcd) begin
                bad++;
                $display("FAIL release v=%0d out_valid/in_ready=%b bcd=%06h required 01 bcd=%06h", v, {out_valid, in_ready}, out_bcd, e.bcd);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bin = '0;
        out_ready = 1'b0;
        in_valid4 = 1'b0;
        in_bin4 = '0;
        out_ready4 = 1'b0;
        repeat (3) tick();
        tot++;
        if ({in_ready, out_valid, out_bcd, out_neg, busy} !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals in_ready=%b out_valid=%b bcd=%06h neg=%b busy=%b required 1 0 000000 0 0", in_ready, out_valid, out_bcd, out_neg, busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        do_conv(16'd0,    24'h000000, 1'b0, 1'b1);
        do_conv(16'd9999, 24'h009999, 1'b0, 1'b1);
        do_conv(16'd1234, 24'h001234, 1'b0, 1'b1);
`ifndef BIN2BCD_SIGNED_EN
        do_conv(16'd65535, 24'h065535, 1'b0, 1'b1);
        do_conv(16'd40960, 24'h040960, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_signed();
`ifdef BIN2BCD_SIGNED_EN
        do_conv(16'h8000, 24'h032768, 1'b1, 1'b1);
        do_conv(16'hFFFF, 24'h000001, 1'b1, 1'b1);
        do_conv(16'h7FFF, 24'h032767, 1'b0, 1'b1);
        do_conv(16'hFB2E, 24'h001234, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_sweep();
        logic [15:0] edge_v[12];
        logic [15:0] v;
        exp_t        e;
        edge_v = '{16'd1, 16'd5, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999,
                   16'd1000, 16'd10000, 16'd32767, 16'd32768, 16'd65534};
        for (int i = 0; i < 12; i++) begin
            e = ref_conv(edge_v[i]);
            do_conv(edge_v[i], e.bcd, e.neg, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            v = 16'($urandom_range(65535, 0));
            e = ref_conv(v);
            do_conv(v, e.bcd, e.neg, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int   n;
        exp_t e;
        exp_q.push_back('{bcd: 24'h004711, neg: 1'b0});
        in_bin    = 16'd4711;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        tot++;
        if (out_valid !== 1'b1 || out_bcd !== e.bcd) begin
            bad++;
            $display("FAIL bp_first out_valid=%b bcd=%06h required 1 bcd=%06h", out_valid, out_bcd, e.bcd);
        end
        in_bin   = 16'd321;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tot++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || out_bcd !== e.bcd) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b busy=%b bcd=%06h required 1 0 0 %06h", i, out_valid, in_ready, busy, out_bcd, e.bcd);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tot++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== e.bcd) begin
            bad++;
            $display("FAIL bp_release out_valid=%b in_ready=%b bcd=%06h required 0 1 %06h", out_valid, in_ready, out_bcd, e.bcd);
        end
        tick();
        tot++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_accept busy=%b in_ready=%b required 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_conv();
        exp_q.push_back('{bcd: 24'h004321, neg: 1'b0});
        in_bin    = 16'd4321;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        tot++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy busy=%b required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tot++;
        if ({in_ready, out_valid, out_bcd, out_neg, busy} !== {1'b1, 1'b0, 24'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset in_ready=%b out_valid=%b bcd=%06h neg=%b busy=%b required 1 0 000000 0 0", in_ready, out_valid, out_bcd, out_neg, busy);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        do_conv(16'd1234, 24'h001234, 1'b0, 1'b1);
    endtask

    task automatic test_min_width();
        int   n;
        exp_t e;
`ifdef BIN2BCD_SIGNED_EN
        exp_q.push_back('{bcd: 24'h000001, neg: 1'b1});
`else
        exp_q.push_back('{bcd: 24'h000015, neg: 1'b0});
`endif
        in_bin4    = 4'd15;
        in_valid4  = 1'b1;
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (out_valid4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tot++;
        if (n != 4) begin
            bad++;
            $display("FAIL w4_latency cycles=%0d required 4", n);
        end
        e = exp_q.pop_front();
        tot++;
        if (out_bcd4 !== e.bcd[7:0] || out_neg4 !== e.neg) begin
            bad++;
            $display("FAIL w4_result got bcd=%02h neg=%b required bcd=%02h neg=%b", out_bcd4, out_neg4, e.bcd[7:0], e.neg);
        end
        tick();
        tot++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL w4_release in_ready=%b out_valid=%b required 1 0", in_ready4, out_valid4);
        end
    endtask

    initial begin
        tot = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_signed();
        test_backpressure();
        test_reset_mid_conv();
        test_min_width();
        test_sweep();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
